// File: rtl/x74xx14_filtered.sv
// rtl/x74xx14_filtered.sv - N-channel synchronised, debounced Schmitt-style inverter (74xx14 model)
// Optional macro X74XX14_EDGE_DETECT_EN adds edge_o, a one-cycle pulse per committed level change.
module x74xx14_filtered #(
    parameter int CHANNELS      = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clock_50,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] A,
    output logic [CHANNELS-1:0] Y,
    output logic [CHANNELS-1:0] busy
`ifdef X74XX14_EDGE_DETECT_EN
    ,
    output logic [CHANNELS-1:0] edge_o
`endif
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [CHANNELS-1:0] s1_q;
    logic [CHANNELS-1:0] s2_q;
    logic [CHANNELS-1:0] f_q;
    logic [CHANNELS-1:0] f_d;
    logic [CHANNELS-1:0] mismatch;
    logic [CHANNELS-1:0] commit;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];

    // An unknown synchronised level counts as a mismatch, so X never silently matches f.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            mismatch[i] = (s2_q[i] !== f_q[i]);
            commit[i]   = mismatch[i] && (cnt_q[i] == CNT_MAX);
            f_d[i]      = commit[i] ? s2_q[i] : f_q[i];
            if (!mismatch[i] || commit[i]) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
            f_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q <= A;
            s2_q <= s1_q;
            f_q  <= f_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign Y    = ~f_q;
    assign busy = mismatch;

`ifdef X74XX14_EDGE_DETECT_EN
    // Named edge_o because edge is a reserved word; registered so it lines up with the new Y.
    logic [CHANNELS-1:0] edge_q;

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            edge_q <= '0;
        end else begin
            edge_q <= commit;
        end
    end

    assign edge_o = edge_q;
`endif

endmodule

// File: tb/tb_x74xx14_filtered.sv
// tb/tb_x74xx14_filtered.sv - table-driven scoreboard bench for x74xx14_filtered
module tb_x74xx14_filtered;

    localparam int N = 6;

    logic         clock_50 = 1'b0;
    logic         reset_n;
    logic [N-1:0] A;
    logic [N-1:0] Y;
    logic [N-1:0] busy;
`ifdef X74XX14_EDGE_DETECT_EN
    logic [N-1:0] edge_o;
`endif

    always #5 clock_50 = ~clock_50;

    x74xx14_filtered #(
        .CHANNELS     (N),
        .STABLE_CYCLES(4)
    ) dut (
        .clock_50(clock_50),
        .reset_n (reset_n),
        .A       (A),
        .Y       (Y),
        .busy    (busy)
`ifdef X74XX14_EDGE_DETECT_EN
        ,
        .edge_o  (edge_o)
`endif
    );

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] y;
        logic [N-1:0] b;
        string        nm;
    } vec_t;

    typedef struct {
        logic [N-1:0] y;
        logic [N-1:0] b;
        string        nm;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive A at the falling edge, let one rising edge pass, compare at the next falling edge.
    task automatic step(input logic [N-1:0] a, input logic [N-1:0] ey, input logic [N-1:0] eb,
                        input string nm);
        exp_t e;
        A    = a;
        e.y  = ey;
        e.b  = eb;
        e.nm = nm;
        sb.push_back(e);
        @(posedge clock_50);
        @(negedge clock_50);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty got 0 expected 1", nm);
        end else begin
            e = sb.pop_front();
            check({e.nm, ".Y"}, Y, e.y);
            check({e.nm, ".busy"}, busy, e.b);
        end
    endtask

    // Expected rows for a full settled transition from filtered level fold to new input a.
    function automatic void add_settle(input logic [N-1:0] fold, input logic [N-1:0] a,
                                       input string nm);
        tbl.push_back('{a, ~fold, '0, nm});
        for (int k = 0; k < 4; k++) tbl.push_back('{a, ~fold, fold ^ a, nm});
        tbl.push_back('{a, ~a, '0, nm});
        tbl.push_back('{a, ~a, '0, nm});
    endfunction

    task automatic settle(input logic [N-1:0] fold, input logic [N-1:0] a, input string nm);
        step(a, ~fold, '0, nm);
        for (int k = 0; k < 4; k++) step(a, ~fold, fold ^ a, nm);
        step(a, ~a, '0, nm);
        step(a, ~a, '0, nm);
    endtask

    initial begin
        add_settle(6'h00, 6'h2A, "release");
        add_settle(6'h2A, 6'h00, "to_zero");
        add_settle(6'h00, 6'h3F, "latency_rise");
        add_settle(6'h3F, 6'h00, "latency_fall");

        reset_n = 1'b0;
        A       = 6'b101010;
        repeat (2) @(posedge clock_50);
        @(negedge clock_50);
        check("reset.Y", Y, 6'h3F);
        check("reset.busy", busy, 6'h00);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].a, tbl[i].y, tbl[i].b, tbl[i].nm);
        end

        // 3-clock pulse on channel 0 never reaches Y
        step(6'h01, 6'h3F, 6'h00, "glitch3");
        step(6'h01, 6'h3F, 6'h01, "glitch3");
        step(6'h01, 6'h3F, 6'h01, "glitch3");
        step(6'h00, 6'h3F, 6'h01, "glitch3");
        step(6'h00, 6'h3F, 6'h00, "glitch3");
        step(6'h00, 6'h3F, 6'h00, "glitch3");

        // 4-clock pulse commits and Y[0] stays low for exactly 4 cycles
        step(6'h01, 6'h3F, 6'h00, "pulse4");
        for (int k = 0; k < 3; k++) step(6'h01, 6'h3F, 6'h01, "pulse4");
        step(6'h00, 6'h3F, 6'h01, "pulse4");
        for (int k = 0; k < 4; k++) step(6'h00, 6'h3E, 6'h01, "pulse4_low");
        step(6'h00, 6'h3F, 6'h00, "pulse4_end");
        step(6'h00, 6'h3F, 6'h00, "pulse4_end");

        // bounce on channel 2 restarts the count
        step(6'h04, 6'h3F, 6'h00, "bounce");
        step(6'h04, 6'h3F, 6'h04, "bounce");
        step(6'h00, 6'h3F, 6'h04, "bounce");
        step(6'h04, 6'h3F, 6'h00, "bounce");
        for (int k = 0; k < 4; k++) step(6'h04, 6'h3F, 6'h04, "bounce_count");
        step(6'h04, 6'h3B, 6'h00, "bounce_commit");
        settle(6'h04, 6'h00, "bounce_clear");

        // channels 1/4 together, channel 5 two clocks later
        step(6'h12, 6'h3F, 6'h00, "indep");
        step(6'h12, 6'h3F, 6'h12, "indep");
        step(6'h32, 6'h3F, 6'h12, "indep");
        step(6'h32, 6'h3F, 6'h32, "indep");
        step(6'h32, 6'h3F, 6'h32, "indep");
        step(6'h32, 6'h2D, 6'h20, "indep_14");
        step(6'h32, 6'h2D, 6'h20, "indep_14");
        step(6'h32, 6'h0D, 6'h00, "indep_5");
        settle(6'h32, 6'h00, "indep_clear");

        // asynchronous reset in the middle of a count
        step(6'h3F, 6'h3F, 6'h00, "midreset");
        for (int k = 0; k < 3; k++) step(6'h3F, 6'h3F, 6'h3F, "midreset");
        #2 reset_n = 1'b0;
        #1;
        check("midreset_async.Y", Y, 6'h3F);
        check("midreset_async.busy", busy, 6'h00);
        @(posedge clock_50);
        @(negedge clock_50);
        check("midreset_held.busy", busy, 6'h00);
        reset_n = 1'b1;
        step(6'h3F, 6'h3F, 6'h00, "post_reset");
        for (int k = 0; k < 4; k++) step(6'h3F, 6'h3F, 6'h3F, "post_reset");
        step(6'h3F, 6'h00, 6'h00, "post_reset_commit");

        check("scoreboard_empty", 6'(sb.size()), 6'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
